// File: rtl/updown_mon_pkg.sv
// Shared constants for the up/down counter monitor: FSM encoding and 7-segment glyphs.
// Optional display output is enabled with the SEG_DISPLAY_EN macro.
package updown_mon_pkg;

   // Monitor FSM state encoding
   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_TRACK = 2'd1;
   localparam logic [1:0] S_FAULT = 2'd2;

   // Active-low segments {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   // Hex digit to segment pattern; entry [0] is the rightmost element
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low 7-segment decoder.
module seg7_decode
   import updown_mon_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_c_o
);

   // Table lookup of the glyph for the digit
   always_comb begin
      seg_c_o = SEG_HEX[digit_i];
   end

endmodule

// File: rtl/updown_count_monitor.sv
// Step checker for a synchronous up/down counter: flags illegal steps (sticky fault),
// counts legal wrap-arounds and reports terminal count. Define SEG_DISPLAY_EN to add a
// registered 7-segment output showing the sampled count (or '-' while faulted).
module updown_count_monitor
   import updown_mon_pkg::*;
#(
   parameter int unsigned CNT_W  = 3,
   parameter int unsigned WRAP_W = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              m,
   input  logic [CNT_W-1:0]  q,
   input  logic              err_clr,
   output logic              tc,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wraps,
   output logic              step_err,
   output logic              err_sticky
`ifdef SEG_DISPLAY_EN
   ,
   output logic [6:0]        seg
`endif
);

   localparam logic [CNT_W-1:0]  Q_MAX     = '1;
   localparam logic [WRAP_W-1:0] WRAPS_MAX = '1;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  prev_val_q;
   logic              prev_m_q;
   logic              tc_q, tc_d;
   logic              wrap_pulse_q, wrap_pulse_d;
   logic [WRAP_W-1:0] wraps_q, wraps_d;
   logic              step_err_q, step_err_d;
   logic              err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0]  expected_c;
   logic              is_wrap_c;

   // Next-state and registered-output decode; the step is judged with the previous mode
   always_comb begin
      state_d      = state_q;
      wrap_pulse_d = 1'b0;
      step_err_d   = 1'b0;
      wraps_d      = wraps_q;
      tc_d         = m ? (q == '0) : (q == Q_MAX);
      expected_c   = prev_m_q ? (prev_val_q - CNT_W'(1)) : (prev_val_q + CNT_W'(1));
      is_wrap_c    = prev_m_q ? (prev_val_q == '0) : (prev_val_q == Q_MAX);

      case (state_q)
         S_INIT: begin
            state_d = S_TRACK;
         end
         S_TRACK: begin
            if (q == expected_c) begin
               if (is_wrap_c) begin
                  wrap_pulse_d = 1'b1;
                  if (wraps_q != WRAPS_MAX) begin
                     wraps_d = wraps_q + WRAP_W'(1);
                  end
               end
            end else begin
               step_err_d = 1'b1;
               state_d    = S_FAULT;
            end
         end
         S_FAULT: begin
            if (err_clr) begin
               state_d = S_INIT;
               wraps_d = '0;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase

      err_sticky_d = (state_d == S_FAULT);
   end

   // State, sample capture and output registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q      <= S_INIT;
         prev_val_q   <= '0;
         prev_m_q     <= 1'b0;
         tc_q         <= 1'b0;
         wrap_pulse_q <= 1'b0;
         wraps_q      <= '0;
         step_err_q   <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_val_q   <= q;
         prev_m_q     <= m;
         tc_q         <= tc_d;
         wrap_pulse_q <= wrap_pulse_d;
         wraps_q      <= wraps_d;
         step_err_q   <= step_err_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign tc         = tc_q;
   assign wrap_pulse = wrap_pulse_q;
   assign wraps      = wraps_q;
   assign step_err   = step_err_q;
   assign err_sticky = err_sticky_q;

`ifdef SEG_DISPLAY_EN
   logic [6:0] seg_dec_c;
   logic [6:0] seg_q, seg_d;

   seg7_decode u_seg7_decode (
      .digit_i (4'(q)),
      .seg_c_o (seg_dec_c)
   );

   // Glyph for the value being captured, replaced by a dash while faulted
   always_comb begin
      seg_d = seg_dec_c;
      if (state_d == S_FAULT) begin
         seg_d = SEG_DASH;
      end
   end

   // Display register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         seg_q <= SEG_OFF;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign seg = seg_q;
`endif

endmodule

// File: tb/tb_updown_count_monitor.sv
// Self-checking bench for updown_count_monitor: a directed vector table, hand-written
// reset/saturation sequences and a randomized run against a behavioural model.
// Two instances share the stimulus: WRAP_W=8 (a) and WRAP_W=2 (b, saturation).
module tb_updown_count_monitor;

   logic       clk = 1'b0;
   logic       clr;
   logic       m;
   logic [2:0] q;
   logic       err_clr;

   logic       tc_a, wp_a, se_a, st_a;
   logic [7:0] wraps_a;
   logic       tc_b, wp_b, se_b, st_b;
   logic [1:0] wraps_b;
`ifdef SEG_DISPLAY_EN
   logic [6:0] seg_a, seg_b;
`endif

   int checks = 0;
   int errors = 0;

   updown_count_monitor #(.CNT_W(3), .WRAP_W(8)) dut_a (
      .clk(clk), .clr(clr), .m(m), .q(q), .err_clr(err_clr),
      .tc(tc_a), .wrap_pulse(wp_a), .wraps(wraps_a), .step_err(se_a), .err_sticky(st_a)
`ifdef SEG_DISPLAY_EN
      , .seg(seg_a)
`endif
   );

   updown_count_monitor #(.CNT_W(3), .WRAP_W(2)) dut_b (
      .clk(clk), .clr(clr), .m(m), .q(q), .err_clr(err_clr),
      .tc(tc_b), .wrap_pulse(wp_b), .wraps(wraps_b), .step_err(se_b), .err_sticky(st_b)
`ifdef SEG_DISPLAY_EN
      , .seg(seg_b)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr     = 1'b0;
      m       = 1'b0;
      q       = 3'd0;
      err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      clr = 1'b1;
   endtask

   // Segment glyphs for digits 0..7
   function automatic int glyph(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  default: return 7'h78;
      endcase
   endfunction

   // Behavioural model: spec rules in plain arithmetic
   int  md_pq, md_pm, md_w8, md_w2;
   bit  md_armed, md_fault;
   bit  ex_tc, ex_wp, ex_se;
   int  ex_seg;

   function automatic void model_reset();
      md_pq = 0; md_pm = 0; md_w8 = 0; md_w2 = 0;
      md_armed = 0; md_fault = 0;
   endfunction

   function automatic void model_edge(input int mi, input int qi, input bit ec);
      int want;
      ex_tc = (mi != 0) ? (qi == 0) : (qi == 7);
      ex_wp = 0;
      ex_se = 0;
      if (md_fault) begin
         if (ec) begin
            md_fault = 0; md_armed = 0; md_w8 = 0; md_w2 = 0;
         end
      end else if (!md_armed) begin
         md_armed = 1;
      end else begin
         want = (md_pq + ((md_pm != 0) ? 7 : 1)) % 8;
         if (qi == want) begin
            if ((md_pm == 0 && md_pq == 7) || (md_pm != 0 && md_pq == 0)) begin
               ex_wp = 1;
               if (md_w8 < 255) md_w8++;
               if (md_w2 < 3) md_w2++;
            end
         end else begin
            ex_se = 1;
            md_fault = 1;
         end
      end
      ex_seg = md_fault ? 7'h3F : glyph(qi);
      md_pq = qi;
      md_pm = mi;
   endfunction

   typedef struct {
      bit m; int q; bit ec;
      bit tc; bit wp; bit se; bit st; int w8; int w2;
   } vec_t;

   vec_t vt[27];

   initial begin
      int wp_count;
      int lq, lm, nq;

      // m q ec | tc wp se st w8 w2
      vt[0]  = '{0, 0, 0,  0, 0, 0, 0, 0, 0};
      vt[1]  = '{0, 1, 0,  0, 0, 0, 0, 0, 0};
      vt[2]  = '{0, 2, 0,  0, 0, 0, 0, 0, 0};
      vt[3]  = '{0, 3, 0,  0, 0, 0, 0, 0, 0};
      vt[4]  = '{0, 4, 0,  0, 0, 0, 0, 0, 0};
      vt[5]  = '{0, 5, 0,  0, 0, 0, 0, 0, 0};
      vt[6]  = '{0, 6, 0,  0, 0, 0, 0, 0, 0};
      vt[7]  = '{0, 7, 0,  1, 0, 0, 0, 0, 0};
      vt[8]  = '{0, 0, 0,  0, 1, 0, 0, 1, 1};
      vt[9]  = '{0, 1, 0,  0, 0, 0, 0, 1, 1};
      vt[10] = '{1, 2, 0,  0, 0, 0, 0, 1, 1};
      vt[11] = '{1, 1, 0,  0, 0, 0, 0, 1, 1};
      vt[12] = '{1, 0, 0,  1, 0, 0, 0, 1, 1};
      vt[13] = '{1, 7, 0,  0, 1, 0, 0, 2, 2};
      vt[14] = '{0, 6, 0,  0, 0, 0, 0, 2, 2};
      vt[15] = '{0, 7, 0,  1, 0, 0, 0, 2, 2};
      vt[16] = '{1, 0, 0,  1, 1, 0, 0, 3, 3};
      vt[17] = '{1, 7, 0,  0, 1, 0, 0, 4, 3};
      vt[18] = '{0, 2, 0,  0, 0, 1, 1, 4, 3};
      vt[19] = '{0, 5, 0,  0, 0, 0, 1, 4, 3};
      vt[20] = '{0, 6, 1,  0, 0, 0, 0, 0, 0};
      vt[21] = '{0, 3, 1,  0, 0, 0, 0, 0, 0};
      vt[22] = '{0, 5, 1,  0, 0, 1, 1, 0, 0};
      vt[23] = '{0, 5, 0,  0, 0, 0, 1, 0, 0};
      vt[24] = '{0, 7, 1,  1, 0, 0, 0, 0, 0};
      vt[25] = '{0, 2, 0,  0, 0, 0, 0, 0, 0};
      vt[26] = '{0, 3, 0,  0, 0, 0, 0, 0, 0};

      // Directed table: up count, reversal, down wrap, illegal step, err_clr handling
      do_reset();
      chk("rst_tc", int'(tc_a), 0);
      chk("rst_wraps", int'(wraps_a), 0);
      chk("rst_sticky", int'(st_a), 0);
      for (int i = 0; i < 27; i++) begin
         m       = vt[i].m;
         q       = 3'(vt[i].q);
         err_clr = vt[i].ec;
         tick();
         chk($sformatf("vec%0d_tc", i), int'(tc_a), int'(vt[i].tc));
         chk($sformatf("vec%0d_wp", i), int'(wp_a), int'(vt[i].wp));
         chk($sformatf("vec%0d_se", i), int'(se_a), int'(vt[i].se));
         chk($sformatf("vec%0d_st", i), int'(st_a), int'(vt[i].st));
         chk($sformatf("vec%0d_w8", i), int'(wraps_a), vt[i].w8);
         chk($sformatf("vec%0d_w2", i), int'(wraps_b), vt[i].w2);
`ifdef SEG_DISPLAY_EN
         if (i == 21) chk("seg_digit3", int'(seg_a), 7'h30);
         if (i == 19) chk("seg_dash", int'(seg_a), 7'h3F);
`endif
      end

      // Saturation: five up-wraps, narrow counter holds at 3, pulse every wrap
      do_reset();
      wp_count = 0;
      m = 1'b0;
      err_clr = 1'b0;
      for (int i = 0; i <= 47; i++) begin
         q = 3'(i % 8);
         tick();
         chk($sformatf("sat%0d_wp", i), int'(wp_b), (i > 0 && i % 8 == 0) ? 1 : 0);
         if (wp_b) wp_count++;
      end
      chk("sat_pulses", wp_count, 5);
      chk("sat_w2_hold", int'(wraps_b), 3);
      chk("sat_w8", int'(wraps_a), 5);
      chk("sat_tc", int'(tc_a), 1);

      // Asynchronous clear mid-operation, away from any clock edge
      #2;
      clr = 1'b0;
      #1;
      chk("aclr_tc", int'(tc_a), 0);
      chk("aclr_wp", int'(wp_a), 0);
      chk("aclr_wraps", int'(wraps_a), 0);
      chk("aclr_wraps_b", int'(wraps_b), 0);
      chk("aclr_se", int'(se_a), 0);
      chk("aclr_st", int'(st_a), 0);
`ifdef SEG_DISPLAY_EN
      chk("aclr_seg", int'(seg_a), 7'h7F);
`endif
      @(negedge clk);
      clr = 1'b1;
      // First sample after clear is capture only, even for a jump
      q = 3'd5;
      tick();
      chk("first_noflag", int'(se_a), 0);
      q = 3'd2;
      tick();
      chk("second_flags", int'(se_a), 1);

      // Randomized run against the model
      do_reset();
      model_reset();
      lq = 0;
      lm = 0;
      for (int n = 0; n < 3000; n++) begin
         nq = (lq + ((lm != 0) ? 7 : 1)) % 8;
         if ($urandom_range(0, 99) < 4) nq = int'($urandom_range(0, 7));
         q       = 3'(nq);
         m       = ($urandom_range(0, 3) == 0) ? ~m : m;
         err_clr = ($urandom_range(0, 7) == 0);
         model_edge(int'(m), nq, err_clr);
         lq = nq;
         lm = int'(m);
         tick();
         chk("rnd_tc", int'(tc_a), int'(ex_tc));
         chk("rnd_wp", int'(wp_a), int'(ex_wp));
         chk("rnd_se", int'(se_a), int'(ex_se));
         chk("rnd_st", int'(st_a), int'(md_fault));
         chk("rnd_w8", int'(wraps_a), md_w8);
         chk("rnd_w2", int'(wraps_b), md_w2);
         chk("rnd_wp_b", int'(wp_b), int'(ex_wp));
         chk("rnd_st_b", int'(st_b), int'(md_fault));
`ifdef SEG_DISPLAY_EN
         chk("rnd_seg", int'(seg_a), ex_seg);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
